// File: rtl/mem_pkg.sv
// Shared encodings and helpers for the RV32 data memory controller.
// Latency: none (types, constants and a pure function only).
// Backpressure: not applicable.
package mem_pkg;

  // Access size encodings as driven on req_size
  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;
  localparam logic [1:0] SZ_RSVD = 2'd3;

  // Controller FSM state encoding
  localparam logic [1:0] MS_IDLE = 2'd0;
  localparam logic [1:0] MS_WAIT = 2'd1;
  localparam logic [1:0] MS_RESP = 2'd2;

  // Flags any access that must be rejected: the reserved size counts as
  // "misaligned" as well, so one predicate guards every side effect.
  function automatic logic mem_misaligned(input logic [1:0] size,
                                          input logic [1:0] addr_lo);
    logic bad;
    case (size)
      SZ_BYTE: bad = 1'b0;
      SZ_HALF: bad = addr_lo[0];
      SZ_WORD: bad = (addr_lo != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering for stores (byte enables + replicated data) and loads (extract + extend).
// Latency: purely combinational.
// Backpressure: none; outputs follow inputs.
module mem_lane_align
  import mem_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  addr_lo,
  input  logic        ld_unsigned,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  be,
  output logic [31:0] wword,
  output logic [31:0] ldata
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  // Store side: replicate the low-order data into every lane, the enables pick the lanes
  always_comb begin
    be    = 4'b0000;
    wword = wdata;
    case (size)
      SZ_BYTE: begin
        be    = 4'b0001 << addr_lo;
        wword = {4{wdata[7:0]}};
      end
      SZ_HALF: begin
        be    = addr_lo[1] ? 4'b1100 : 4'b0011;
        wword = {2{wdata[15:0]}};
      end
      SZ_WORD: begin
        be    = 4'b1111;
        wword = wdata;
      end
      default: begin
        be    = 4'b0000;
        wword = wdata;
      end
    endcase
  end

  // Load side: pick the addressed byte/half, then sign- or zero-extend it
  always_comb begin
    ld_byte = rword[{addr_lo, 3'b000} +: 8];
    ld_half = rword[{addr_lo[1], 4'b0000} +: 16];
    case (size)
      SZ_BYTE: ldata = ld_unsigned ? {24'b0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
      SZ_HALF: ldata = ld_unsigned ? {16'b0, ld_half} : {{16{ld_half[15]}}, ld_half};
      default: ldata = rword;
    endcase
  end

endmodule

// File: rtl/data_mem_ctrl.sv
// Byte-addressed RV32 data memory with valid/ready request/response and programmable wait states.
// Latency: response valid WAIT_STATES+1 cycles after the accepting cycle; one access per 2+WAIT_STATES cycles.
// Backpressure: holds RESP with stable outputs while rsp_ready=0; req_ready only in IDLE.
module data_mem_ctrl
  import mem_pkg::*;
#(
  parameter int ADDR_WIDTH  = 10,
  parameter int WAIT_STATES = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [31:0]           rsp_rdata,
  output logic                  rsp_error
);

  localparam int         DEPTH   = 2 ** (ADDR_WIDTH - 2);
  localparam logic       NO_WAIT = (WAIT_STATES == 0);
  localparam logic [3:0] WS_LOAD = NO_WAIT ? 4'd0 : 4'(WAIT_STATES - 1);

  logic [1:0]            state;
  logic [3:0]            wait_cnt;
  logic                  r_write;
  logic [1:0]            r_size;
  logic                  r_unsigned;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [31:0]           r_wdata;
  logic [31:0]           mem [DEPTH];

  logic                  accept;
  logic                  access;
  logic                  a_write;
  logic [1:0]            a_size;
  logic                  a_unsigned;
  logic [ADDR_WIDTH-1:0] a_addr;
  logic [31:0]           a_wdata;
  logic                  a_err;
  logic [31:0]           rword;
  logic [3:0]            be;
  logic [31:0]           wword;
  logic [31:0]           ldata;

  assign req_ready = (state == MS_IDLE) && !rst;
  assign rsp_valid = (state == MS_RESP);
  assign accept    = req_valid && req_ready;

  // With no wait states the access happens on the accepting edge, before the
  // request registers are loaded, so the live request is used in IDLE.
  assign a_write    = (state == MS_IDLE) ? req_write    : r_write;
  assign a_size     = (state == MS_IDLE) ? req_size     : r_size;
  assign a_unsigned = (state == MS_IDLE) ? req_unsigned : r_unsigned;
  assign a_addr     = (state == MS_IDLE) ? req_addr     : r_addr;
  assign a_wdata    = (state == MS_IDLE) ? req_wdata    : r_wdata;

  assign access = (state == MS_IDLE) ? (accept && NO_WAIT)
                                     : ((state == MS_WAIT) && (wait_cnt == 4'd0));
  assign a_err  = mem_misaligned(a_size, a_addr[1:0]);
  assign rword  = mem[a_addr[ADDR_WIDTH-1:2]];

  mem_lane_align u_align (
    .size        (a_size),
    .addr_lo     (a_addr[1:0]),
    .ld_unsigned (a_unsigned),
    .wdata       (a_wdata),
    .rword       (rword),
    .be          (be),
    .wword       (wword),
    .ldata       (ldata)
  );

  // FSM and wait-state counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= MS_IDLE;
      wait_cnt <= 4'd0;
    end else begin
      case (state)
        MS_IDLE: begin
          if (accept) begin
            if (NO_WAIT) begin
              state <= MS_RESP;
            end else begin
              state    <= MS_WAIT;
              wait_cnt <= WS_LOAD;
            end
          end
        end
        MS_WAIT: begin
          if (wait_cnt == 4'd0) state <= MS_RESP;
          else                  wait_cnt <= wait_cnt - 4'd1;
        end
        MS_RESP: begin
          if (rsp_ready) state <= MS_IDLE;
        end
        default: state <= MS_IDLE;
      endcase
    end
  end

  // Request capture on acceptance; later changes on req_* are ignored
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_write    <= 1'b0;
      r_size     <= SZ_BYTE;
      r_unsigned <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= 32'd0;
    end else if (accept) begin
      r_write    <= req_write;
      r_size     <= req_size;
      r_unsigned <= req_unsigned;
      r_addr     <= req_addr;
      r_wdata    <= req_wdata;
    end
  end

  // Response registers load on the edge entering RESP and hold through any stall
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_rdata <= 32'd0;
      rsp_error <= 1'b0;
    end else if (access) begin
      rsp_error <= a_err;
      rsp_rdata <= (a_err || a_write) ? 32'd0 : ldata;
    end
  end

  // Storage write, lane-masked; rejected accesses leave memory untouched
  always_ff @(posedge clk) begin
    if (access && a_write && !a_err) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[a_addr[ADDR_WIDTH-1:2]][8*i +: 8] <= wword[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Self-checking bench: three controllers (0, 1 and 3 wait states) against a byte-array model.
// Latency: checks response latency of WAIT_STATES+1 cycles per transaction.
// Backpressure: exercises rsp_ready stalls and reset during WAIT.
module tb_data_mem_ctrl;

  localparam int AW = 10;
  localparam int ND = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_write;
  logic [1:0]    req_size;
  logic          req_unsigned;
  logic [AW-1:0] req_addr;
  logic [31:0]   req_wdata;
  logic          req_valid_a [ND];
  logic          req_ready_a [ND];
  logic          rsp_valid_a [ND];
  logic          rsp_ready_a [ND];
  logic [31:0]   rsp_rdata_a [ND];
  logic          rsp_error_a [ND];

  int checks = 0;
  int errors = 0;

  // Reference memory: one byte array per controller
  logic [7:0] mm [ND][2**AW];

  always #5 clk = ~clk;

  for (genvar g = 0; g < ND; g++) begin : g_dut
    data_mem_ctrl #(
      .ADDR_WIDTH  (AW),
      .WAIT_STATES ((g == 0) ? 0 : ((g == 1) ? 1 : 3))
    ) u_dut (
      .clk          (clk),
      .rst          (rst),
      .req_valid    (req_valid_a[g]),
      .req_ready    (req_ready_a[g]),
      .req_write    (req_write),
      .req_size     (req_size),
      .req_unsigned (req_unsigned),
      .req_addr     (req_addr),
      .req_wdata    (req_wdata),
      .rsp_valid    (rsp_valid_a[g]),
      .rsp_ready    (rsp_ready_a[g]),
      .rsp_rdata    (rsp_rdata_a[g]),
      .rsp_error    (rsp_error_a[g])
    );
  end

  function automatic int ws_of(input int d);
    return (d == 0) ? 0 : ((d == 1) ? 1 : 3);
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Behavioural model: an access is a run of 1/2/4 little-endian bytes
  task automatic model(input int d, input bit wr, input logic [1:0] sz, input bit uns,
                       input logic [AW-1:0] a, input logic [31:0] wd,
                       output logic [31:0] erd, output bit eerr);
    int nb;
    erd  = 32'd0;
    nb   = (sz == 2'd0) ? 1 : ((sz == 2'd1) ? 2 : 4);
    eerr = (sz == 2'd3) || ((a % nb) != 0);
    if (!eerr) begin
      for (int i = 0; i < nb; i++) begin
        if (wr) mm[d][int'(a) + i] = wd[8*i +: 8];
        else    erd[8*i +: 8] = mm[d][int'(a) + i];
      end
      if (!wr && !uns && nb < 4 && erd[8*nb-1]) erd = erd | (32'hFFFF_FFFF << (8*nb));
    end
  endtask

  task automatic txn(input int d, input bit wr, input logic [1:0] sz, input bit uns,
                     input logic [AW-1:0] a, input logic [31:0] wd, input int stall,
                     output logic [31:0] got_rd, output logic got_err);
    logic [31:0] erd;
    bit          eerr;
    int          cyc;
    model(d, wr, sz, uns, a, wd, erd, eerr);
    @(negedge clk);
    req_write = wr; req_size = sz; req_unsigned = uns; req_addr = a; req_wdata = wd;
    req_valid_a[d] = 1'b1;
    rsp_ready_a[d] = (stall == 0);
    check("req_ready_idle", 32'(req_ready_a[d]), 32'd1);
    @(posedge clk);
    @(negedge clk);
    // Scramble the request lines to show they are ignored after acceptance
    req_valid_a[d] = 1'b0;
    req_write = 1'($urandom); req_size = 2'($urandom); req_unsigned = 1'($urandom);
    req_addr = AW'($urandom); req_wdata = $urandom;
    cyc = 1;
    while (!rsp_valid_a[d] && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    check("latency", 32'(cyc), 32'(ws_of(d) + 1));
    got_rd  = rsp_rdata_a[d];
    got_err = rsp_error_a[d];
    check("rdata", got_rd, erd);
    check("error", 32'(got_err), 32'(eerr));
    for (int i = 0; i < stall; i++) begin
      check("stall_vld", 32'(rsp_valid_a[d]), 32'd1);
      check("stall_rdy", 32'(req_ready_a[d]), 32'd0);
      check("stall_dat", rsp_rdata_a[d], erd);
      @(negedge clk);
    end
    rsp_ready_a[d] = 1'b1;
    @(negedge clk);
    check("done_vld", 32'(rsp_valid_a[d]), 32'd0);
    check("done_rdy", 32'(req_ready_a[d]), 32'd1);
  endtask

  logic [31:0] rd, prior, prior2;
  logic        er;

  initial begin
    #900000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    req_write = 1'b0; req_size = 2'd0; req_unsigned = 1'b0; req_addr = '0; req_wdata = 32'd0;
    for (int d = 0; d < ND; d++) begin
      req_valid_a[d] = 1'b0;
      rsp_ready_a[d] = 1'b1;
    end
    repeat (3) @(negedge clk);
    for (int d = 0; d < ND; d++) begin
      check("rst_req_ready", 32'(req_ready_a[d]), 32'd0);
      check("rst_rsp_valid", 32'(rsp_valid_a[d]), 32'd0);
      check("rst_rsp_rdata", rsp_rdata_a[d], 32'd0);
      check("rst_rsp_error", 32'(rsp_error_a[d]), 32'd0);
    end
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_ready", 32'(req_ready_a[0]), 32'd1);

    // Give every word a known value so the model never sees undefined bytes
    for (int d = 0; d < ND; d++)
      for (int w = 0; w < 2**(AW-2); w++)
        txn(d, 1'b1, 2'd2, 1'b0, AW'(w * 4), $urandom, 0, rd, er);

    // Word store / load
    txn(1, 1'b1, 2'd2, 1'b0, 10'h010, 32'hDEADBEEF, 0, rd, er);
    txn(1, 1'b0, 2'd2, 1'b0, 10'h010, 32'h0, 0, rd, er);
    check("lw_deadbeef", rd, 32'hDEADBEEF);

    // Byte lanes and extension
    txn(1, 1'b1, 2'd2, 1'b0, 10'h020, 32'h11223344, 0, rd, er);
    txn(1, 1'b1, 2'd0, 1'b0, 10'h021, 32'hFFFF_FFAB, 0, rd, er);
    txn(1, 1'b0, 2'd2, 1'b0, 10'h020, 32'h0, 0, rd, er);
    check("lw_bytemask", rd, 32'h1122AB44);
    txn(1, 1'b0, 2'd0, 1'b0, 10'h021, 32'h0, 0, rd, er);
    check("lb_sext", rd, 32'hFFFFFFAB);
    txn(1, 1'b0, 2'd0, 1'b1, 10'h021, 32'h0, 0, rd, er);
    check("lbu_zext", rd, 32'h000000AB);

    // Half store and extension
    txn(1, 1'b0, 2'd2, 1'b0, 10'h030, 32'h0, 0, prior, er);
    txn(1, 1'b1, 2'd1, 1'b0, 10'h032, 32'h1234_8001, 0, rd, er);
    txn(1, 1'b0, 2'd2, 1'b0, 10'h030, 32'h0, 0, rd, er);
    check("lw_halfmask", rd, {16'h8001, prior[15:0]});
    txn(1, 1'b0, 2'd1, 1'b0, 10'h032, 32'h0, 0, rd, er);
    check("lh_sext", rd, 32'hFFFF8001);
    txn(1, 1'b0, 2'd1, 1'b1, 10'h032, 32'h0, 0, rd, er);
    check("lhu_zext", rd, 32'h00008001);

    // Misaligned and reserved-size accesses have no side effects
    txn(1, 1'b0, 2'd2, 1'b0, 10'h040, 32'h0, 0, prior, er);
    txn(1, 1'b1, 2'd2, 1'b0, 10'h041, 32'h12345678, 0, rd, er);
    check("sw_mis_err", 32'(er), 32'd1);
    check("sw_mis_rdata", rd, 32'd0);
    txn(1, 1'b1, 2'd3, 1'b0, 10'h040, 32'h12345678, 0, rd, er);
    check("rsvd_err", 32'(er), 32'd1);
    txn(1, 1'b0, 2'd2, 1'b0, 10'h040, 32'h0, 0, rd, er);
    check("lw_unchanged", rd, prior);
    txn(1, 1'b0, 2'd1, 1'b0, 10'h043, 32'h0, 0, rd, er);
    check("lh_mis_err", 32'(er), 32'd1);

    // Response back-pressure
    txn(1, 1'b0, 2'd2, 1'b0, 10'h010, 32'h0, 5, rd, er);
    check("stall_lw", rd, 32'hDEADBEEF);

    // Reset while a store sits in WAIT (3 wait states)
    txn(2, 1'b0, 2'd2, 1'b0, 10'h050, 32'h0, 0, prior2, er);
    txn(2, 1'b0, 2'd2, 1'b0, 10'h054, 32'h0, 0, rd, er);
    @(negedge clk);
    req_write = 1'b1; req_size = 2'd2; req_unsigned = 1'b0; req_addr = 10'h050; req_wdata = 32'h55;
    req_valid_a[2] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid_a[2] = 1'b0;
    check("in_wait_vld", 32'(rsp_valid_a[2]), 32'd0);
    check("in_wait_rdy", 32'(req_ready_a[2]), 32'd0);
    rst = 1'b1;
    #1;
    check("midrst_rdy", 32'(req_ready_a[2]), 32'd0);
    check("midrst_vld", 32'(rsp_valid_a[2]), 32'd0);
    check("midrst_rdata", rsp_rdata_a[2], 32'd0);
    check("midrst_err", 32'(rsp_error_a[2]), 32'd0);
    repeat (4) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    txn(2, 1'b0, 2'd2, 1'b0, 10'h050, 32'h0, 0, rd, er);
    check("aborted_store", rd, prior2);

    // Zero wait states: response in the cycle after accept
    txn(0, 1'b1, 2'd2, 1'b0, 10'h050, 32'h55, 0, rd, er);
    txn(0, 1'b0, 2'd2, 1'b0, 10'h050, 32'h0, 2, rd, er);
    check("ws0_lw", rd, 32'h55);

    // Randomized traffic on every controller
    for (int d = 0; d < ND; d++) begin
      for (int n = 0; n < 60; n++) begin
        logic [1:0]    sz;
        logic [AW-1:0] a;
        sz = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
        a  = AW'($urandom);
        if ($urandom_range(0, 9) < 7) begin
          if (sz == 2'd1) a[0] = 1'b0;
          if (sz == 2'd2) a[1:0] = 2'b00;
        end
        txn(d, 1'($urandom), sz, 1'($urandom), a, $urandom, $urandom_range(0, 2), rd, er);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
